fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/branch_lut.sv | 28 ++
 rtl/fetch_ctrl.sv | 95 +++++++++
 tb/tb_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/PC sequencing stage.
package fetch_pkg;

  localparam int unsigned PW_DEF = 10;
  localparam int unsigned LW_DEF = 5;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch target ROM indexed by the instruction operand field.
// Entries are fixed constants; relative entries are two's-complement offsets.
module branch_lut #(
  parameter int unsigned PW = 10,
  parameter int unsigned LW = 5
) (
  input  logic [LW-1:0] lut_idx,
  output logic [PW-1:0] target
);

  always_comb begin
    target = '0;
    case (lut_idx)
      LW'(0):  target = PW'(32'h100);
      LW'(1):  target = PW'(32'h020);
      LW'(2):  target = PW'(-2);
      LW'(3):  target = PW'(32'h040);
      LW'(4):  target = PW'(32'h004);
      LW'(5):  target = PW'(32'h200);
      LW'(6):  target = PW'(-1);
      LW'(7):  target = PW'(-4);
      LW'(8):  target = PW'(32'h080);
      LW'(9):  target = PW'(8);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter, start/halt sequencing and retired-instruction counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          br_en,
  input  logic          br_cond,
  input  logic          rel_mode,
  input  logic [LW-1:0] lut_idx,
  output logic [PW-1:0] pc,
  output logic          running,
  output logic          done,
  output logic [15:0]   instr_cnt
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cnt_inc;
  logic [PW-1:0] lut_target;

  branch_lut #(
    .PW (PW),
    .LW (LW)
  ) u_branch_lut (
    .lut_idx (lut_idx),
    .target  (lut_target)
  );

  // Saturating increment: the counter sticks at its maximum.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt_req) begin
            state_d = HALT;
          end else if (br_en && br_cond) begin
            pc_d = rel_mode ? pc_q + lut_target : lut_target;
          end else begin
            pc_d = pc_q + PW'(1);
          end
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign instr_cnt = cnt_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: reference model feeds an expected-value queue.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] cnt;
    logic        run;
    logic        done;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset, start, stall, halt_req, br_en, br_cond, rel_mode;
  logic [4:0]  lut_idx;
  logic [9:0]  pc;
  logic        running, done;
  logic [15:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  snap_t exp_q[$];
  snap_t obs_q[$];

  // Reference model state: 0 idle, 1 run, 2 halt
  int          m_st  = 0;
  logic [9:0]  m_pc  = '0;
  logic [15:0] m_cnt = '0;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .halt_req  (halt_req),
    .br_en     (br_en),
    .br_cond   (br_cond),
    .rel_mode  (rel_mode),
    .lut_idx   (lut_idx),
    .pc        (pc),
    .running   (running),
    .done      (done),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] lut_model(input logic [4:0] idx);
    case (idx)
      5'd3:    return 10'h040;
      5'd7:    return 10'h3FC;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // One clock: drive at negedge, advance model, sample 1ns after the edge.
  task automatic cyc(input logic rst, input logic st, input logic stl, input logic hlt,
                     input logic be, input logic bc, input logic rm, input logic [4:0] idx);
    @(negedge clk);
    reset = rst; start = st; stall = stl; halt_req = hlt;
    br_en = be; br_cond = bc; rel_mode = rm; lut_idx = idx;
    if (rst) begin
      m_st = 0; m_pc = '0; m_cnt = '0;
    end else begin
      case (m_st)
        0: begin
          m_pc = '0;
          if (st) begin m_st = 1; m_cnt = '0; end
        end
        1: if (!stl) begin
          m_cnt = sat_inc(m_cnt);
          if (hlt) m_st = 2;
          else if (be && bc) m_pc = rm ? m_pc + lut_model(idx) : lut_model(idx);
          else m_pc = m_pc + 10'd1;
        end
        default: if (st) begin m_st = 1; m_pc = '0; m_cnt = '0; end
      endcase
    end
    exp_q.push_back({m_pc, m_cnt, m_st == 1, m_st == 2});
    @(posedge clk);
    #1;
    obs_q.push_back({pc, instr_cnt, running, done});
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_reset;
    snap_t e, o;
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd0);
    cyc(1, 1, 0, 0, 1, 1, 0, 5'd3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL reset_sb got=%h want=%h", o, e); n_bad++; end
    end
    n_cmp++;
    if ({pc, instr_cnt, running, done} !== 28'h0) begin
      $display("FAIL reset_vals got pc=%h cnt=%h run=%b done=%b want all 0",
               pc, instr_cnt, running, done);
      n_bad++;
    end
  endtask

  task automatic test_start;
    snap_t e, o;
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0);
    n_cmp++;
    if (pc !== 10'h000 || running !== 1'b1) begin
      $display("FAIL start_run got pc=%h run=%b want pc=000 run=1", pc, running); n_bad++;
    end
    seq(3);
    n_cmp++;
    if (pc !== 10'h003) begin $display("FAIL start_seq got=%h want=003", pc); n_bad++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL start_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  task automatic test_abs_branch;
    snap_t e, o;
    seq(2);
    cyc(0, 0, 0, 0, 1, 1, 0, 5'd3);
    n_cmp++;
    if (pc !== 10'h040) begin $display("FAIL abs_taken got=%h want=040", pc); n_bad++; end
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0);
    seq(5);
    cyc(0, 0, 0, 0, 1, 0, 0, 5'd3);
    n_cmp++;
    if (pc !== 10'h006) begin $display("FAIL abs_untaken got=%h want=006", pc); n_bad++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL abs_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  task automatic test_rel_branch;
    snap_t e, o;
    seq(10);
    cyc(0, 0, 0, 0, 1, 1, 1, 5'd7);
    n_cmp++;
    if (pc !== 10'h00C) begin $display("FAIL rel_back got=%h want=00C", pc); n_bad++; end
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0);
    seq(2);
    cyc(0, 0, 0, 0, 1, 1, 1, 5'd7);
    n_cmp++;
    if (pc !== 10'h3FE) begin $display("FAIL rel_wrap got=%h want=3FE", pc); n_bad++; end
    seq(2);
    n_cmp++;
    if (pc !== 10'h000) begin $display("FAIL pc_wrap got=%h want=000", pc); n_bad++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL rel_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  task automatic test_stall_halt;
    snap_t e, o;
    logic [15:0] c0;
    seq(8);
    c0 = instr_cnt;
    // Branch, halt and start asserted under stall must all be ignored.
    cyc(0, 0, 1, 0, 0, 0, 0, 5'd0);
    cyc(0, 1, 1, 1, 0, 0, 0, 5'd0);
    cyc(0, 0, 1, 0, 1, 1, 0, 5'd3);
    n_cmp++;
    if (pc !== 10'h008 || instr_cnt !== c0) begin
      $display("FAIL stall_hold got pc=%h cnt=%h want pc=008 cnt=%h", pc, instr_cnt, c0);
      n_bad++;
    end
    cyc(0, 1, 0, 1, 1, 1, 0, 5'd3);
    n_cmp++;
    if (done !== 1'b1 || running !== 1'b0 || pc !== 10'h008 || instr_cnt !== c0 + 16'd1) begin
      $display("FAIL halt got done=%b pc=%h cnt=%h want done=1 pc=008 cnt=%h",
               done, pc, instr_cnt, c0 + 16'd1);
      n_bad++;
    end
    cyc(0, 0, 0, 0, 1, 1, 0, 5'd3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL stall_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  task automatic test_restart;
    snap_t e, o;
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0);
    n_cmp++;
    if (pc !== 10'h000 || instr_cnt !== 16'h0 || running !== 1'b1 || done !== 1'b0) begin
      $display("FAIL restart got pc=%h cnt=%h run=%b want pc=000 cnt=0000 run=1",
               pc, instr_cnt, running);
      n_bad++;
    end
    seq(3);
    cyc(1, 0, 0, 0, 1, 1, 0, 5'd3);
    n_cmp++;
    if (pc !== 10'h000 || running !== 1'b0 || instr_cnt !== 16'h0) begin
      $display("FAIL reset_mid_branch got pc=%h run=%b cnt=%h want 000/0/0000",
               pc, running, instr_cnt);
      n_bad++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL restart_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  task automatic test_back_to_back;
    snap_t e, o;
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0);
    cyc(0, 0, 0, 0, 1, 1, 0, 5'd3);
    cyc(0, 0, 0, 0, 1, 1, 1, 5'd7);
    cyc(0, 0, 0, 0, 1, 1, 1, 5'd7);
    n_cmp++;
    if (pc !== 10'h038 || instr_cnt !== 16'd3) begin
      $display("FAIL b2b got pc=%h cnt=%h want pc=038 cnt=0003", pc, instr_cnt); n_bad++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL b2b_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  task automatic test_saturation;
    snap_t e, o;
    // Preload just after an edge so the model and the DUT stay in step.
    force dut.cnt_q = 16'hFFFD;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFD;
    seq(5);
    n_cmp++;
    if (instr_cnt !== 16'hFFFF) begin
      $display("FAIL saturate got=%h want=FFFF", instr_cnt); n_bad++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin $display("FAIL sat_sb got=%h want=%h", o, e); n_bad++; end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    br_en = 1'b0; br_cond = 1'b0; rel_mode = 1'b0; lut_idx = '0;
    test_reset();
    test_start();
    test_abs_branch();
    test_rel_branch();
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0);
    test_stall_halt();
    test_restart();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
